// File: rtl/mv_to_code.sv
// mv_to_code: converts a requested voltage in millivolts into a converter code.
//
// The requested voltage is clamped to the full-scale reference. It is then
// scaled to either a 12-bit XADC-style code (/4096) or an 8-bit DAC code (/256),
// rounding half up. The division uses a 24-cycle restoring divider that
// resolves one quotient bit per clock, MSB first.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   request strobe qualifying mv_in / sel_dac
//   in_ready   out  high only while a request can be accepted (IDLE)
//   mv_in      in   [15:0] requested voltage in mV, unsigned
//   sel_dac    in   0 = 12-bit code (/4096), 1 = 8-bit code (/256)
//   out_valid  out  result available, held until out_ready
//   out_ready  in   consumer accepts the result
//   code_out   out  [11:0] result code, bits [11:8] zero in DAC mode
//   clamped    out  input exceeded full scale or rounded code saturated
//   busy       out  high in DIVIDE or DONE
//
// state  | meaning
// IDLE   | waiting for in_valid while in_ready is high
// DIVIDE | 24 restoring-division steps on the captured numerator
// DONE   | result presented on code_out/clamped, waiting for out_ready

module mv_to_code #(
    parameter int FULL_SCALE_MV = 3300
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] mv_in,
    input  logic        sel_dac,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] code_out,
    output logic        clamped,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] FS_MV   = 16'(FULL_SCALE_MV);
    localparam logic [23:0] HALF_FS = 24'(FULL_SCALE_MV / 2);
    localparam logic [4:0]  LAST_STEP = 5'd23;

    state_t      state_q;
    logic [23:0] num_q;
    logic [23:0] quo_q;
    logic [15:0] rem_q;
    logic [4:0]  cnt_q;
    logic        dac_q;
    logic        over_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [11:0] code_q;
    logic        clamped_q;

    logic [15:0] mv_sat_d;
    logic [23:0] num_d;
    logic [16:0] trial_d;
    logic [16:0] diff_d;
    logic        ge_d;
    logic [15:0] rem_d;
    logic [23:0] quo_d;
    logic [11:0] code_d;
    logic        sat_d;

    // Numerator for the incoming request, built from the live inputs so it
    // can be loaded on the accepting edge.
    always_comb begin
        mv_sat_d = (mv_in > FS_MV) ? FS_MV : mv_in;
        if (sel_dac) begin
            num_d = ({8'd0, mv_sat_d} << 8) + HALF_FS;
        end else begin
            num_d = ({8'd0, mv_sat_d} << 12) + HALF_FS;
        end
    end

    // One restoring-division step: shift the next numerator bit into the
    // partial remainder and subtract the divisor if it fits.
    always_comb begin
        trial_d = {rem_q, num_q[23]};
        ge_d    = (trial_d >= {1'b0, FS_MV});
        diff_d  = trial_d - {1'b0, FS_MV};
        rem_d   = ge_d ? diff_d[15:0] : trial_d[15:0];
        quo_d   = {quo_q[22:0], ge_d};
    end

    // Saturation of the completed quotient. This is only meaningful on the
    // last step, where quo_d holds all 24 bits.
    always_comb begin
        code_d = 12'd0;
        sat_d  = 1'b0;
        if (dac_q) begin
            if (quo_d > 24'd255) begin
                code_d = 12'd255;
                sat_d  = 1'b1;
            end else begin
                code_d = {4'd0, quo_d[7:0]};
            end
        end else begin
            if (quo_d > 24'd4095) begin
                code_d = 12'd4095;
                sat_d  = 1'b1;
            end else begin
                code_d = quo_d[11:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            dac_q       <= 1'b0;
            over_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            code_q      <= '0;
            clamped_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // in_ready comes up one edge after reset release, so a
                    // request is never taken on that first edge.
                    in_ready_q <= 1'b1;
                    if (in_ready_q && in_valid) begin
                        num_q      <= num_d;
                        quo_q      <= '0;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        dac_q      <= sel_dac;
                        over_q     <= (mv_in > FS_MV);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    num_q <= {num_q[22:0], 1'b0};
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_STEP) begin
                        code_q      <= code_d;
                        clamped_q   <= over_q | sat_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign code_out  = code_q;
    assign clamped   = clamped_q;

endmodule

// File: tb/tb_mv_to_code.sv
module tb_mv_to_code;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mv_in;
    logic        sel_dac;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] code_out;
    logic        clamped;
    logic        busy;

    int checks;
    int errors;

    mv_to_code #(.FULL_SCALE_MV(3300)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mv_in    (mv_in),
        .sel_dac  (sel_dac),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .code_out (code_out),
        .clamped  (clamped),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mv;
        logic        dac;
        logic [11:0] code;
        logic        clamp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Round-half-up reference: {clamp, code}.
    function automatic logic [12:0] ref_code(input int mv, input bit dac);
        int sat;
        int q;
        int lim;
        bit c;
        sat = (mv > 3300) ? 3300 : mv;
        q   = (sat * (dac ? 256 : 4096) + 1650) / 3300;
        lim = dac ? 255 : 4095;
        c   = (mv > 3300) || (q > lim);
        if (q > lim) q = lim;
        return {c, 12'(q)};
    endfunction

    task automatic start_req(input logic [15:0] mv, input logic dac);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        mv_in    = mv;
        sel_dac  = dac;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mv_in    = 16'hBEEF;
        sel_dac  = ~dac;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_ack", 32'(out_valid), 32'd0);
        check("in_ready_after_ack", 32'(in_ready), 32'd1);
    endtask

    task automatic run_conv(input logic [15:0] mv, input logic dac,
                            output logic [11:0] code, output logic clamp, output int lat);
        start_req(mv, dac);
        wait_valid(lat);
        code  = code_out;
        clamp = clamped;
        release_out();
    endtask

    initial begin
        logic [11:0] code;
        logic        clamp;
        logic [12:0] r;
        int          lat;
        int          seen;

        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        mv_in     = 16'd0;
        sel_dac   = 1'b0;
        out_ready = 1'b0;

        vecs[0]  = '{16'd1650,  1'b1, 12'd128,  1'b0};
        vecs[1]  = '{16'd1000,  1'b0, 12'd1241, 1'b0};
        vecs[2]  = '{16'd1000,  1'b1, 12'd78,   1'b0};
        vecs[3]  = '{16'd0,     1'b0, 12'd0,    1'b0};
        vecs[4]  = '{16'd0,     1'b1, 12'd0,    1'b0};
        vecs[5]  = '{16'd3300,  1'b0, 12'd4095, 1'b1};
        vecs[6]  = '{16'd5000,  1'b1, 12'd255,  1'b1};
        vecs[7]  = '{16'd1650,  1'b0, 12'd2048, 1'b0};
        vecs[8]  = '{16'd3299,  1'b0, 12'd4095, 1'b0};
        vecs[9]  = '{16'd3299,  1'b1, 12'd255,  1'b1};
        vecs[10] = '{16'd65535, 1'b0, 12'd4095, 1'b1};
        vecs[11] = '{16'd3301,  1'b1, 12'd255,  1'b1};
        vecs[12] = '{16'd1,     1'b0, 12'd1,    1'b0};
        vecs[13] = '{16'd1,     1'b1, 12'd0,    1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_code_out", 32'(code_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_first_edge", 32'(in_ready), 32'd1);

        // Directed table
        foreach (vecs[i]) begin
            run_conv(vecs[i].mv, vecs[i].dac, code, clamp, lat);
            check($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].code));
            check($sformatf("vec%0d_clamp", i), 32'(clamp), 32'(vecs[i].clamp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd24);
        end

        // Busy during DIVIDE, and result held for 10 cycles with out_ready low
        // while a second request pulse is ignored.
        start_req(16'd2000, 1'b0);
        check("busy_in_divide", 32'(busy), 32'd1);
        check("in_ready_in_divide", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("hold_latency", 32'(lat), 32'd24);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i == 4);
            mv_in    = 16'd100;
            sel_dac  = 1'b1;
            @(posedge clk);
            #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_code", 32'(code_out), 32'd2482);
            check("hold_clamped", 32'(clamped), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        release_out();
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1;
        end
        check("ignored_pulse_no_conv", 32'(seen), 32'd0);
        check("code_kept_in_idle", 32'(code_out), 32'd2482);

        // out_ready high before DONE has no early effect
        start_req(16'd1000, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        wait_valid(lat);
        check("early_ack_latency", 32'(lat), 32'd24);
        check("early_ack_code", 32'(code_out), 32'd78);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("early_ack_return", 32'(out_valid), 32'd0);

        // Reset in the middle of DIVIDE
        run_conv(16'd1000, 1'b0, code, clamp, lat);
        check("pre_reset_code", 32'(code), 32'd1241);
        start_req(16'd3000, 1'b0);
        repeat (12) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_code", 32'(code_out), 32'd0);
        check("async_rst_clamped", 32'(clamped), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        #11;
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready_low", 32'(in_ready), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("aborted_no_output", 32'(seen), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        run_conv(16'd3000, 1'b0, code, clamp, lat);
        check("post_rst_code", 32'(code), 32'd3724);
        check("post_rst_clamp", 32'(clamp), 32'd0);
        check("post_rst_latency", 32'(lat), 32'd24);

        // Sweep against the reference model in both modes
        for (int d = 0; d < 2; d++) begin
            for (int mv = 0; mv <= 3300; mv += 15) begin
                run_conv(16'(mv), d[0], code, clamp, lat);
                r = ref_code(mv, d[0]);
                check($sformatf("sweep_code_mv%0d_dac%0d", mv, d), 32'(code), 32'(r[11:0]));
                check($sformatf("sweep_clamp_mv%0d_dac%0d", mv, d), 32'(clamp), 32'(r[12]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
